countdown_timer: RTL and testbench

- Two-digit BCD down-counter, the count-down counterpart of the existing 00–99 up-counting stopwatch.
- Loads a preset value 00–99 from switches and decrements once per second once started.
- Supports pause, drives two 7-segment digits, and raises isEnd on reaching 00.
- Contains its own 1 Hz prescaler; sits next to the stopwatch on the board top level.

---
 rtl/countdown_timer.sv | 124 ++++++++++++
 tb/tb_countdown_timer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer with internal prescaler,
// pause, done flag and active-low 7-segment outputs.
module countdown_timer #(
  parameter int CLK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] preset1,
  input  logic [3:0] preset0,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  output logic [6:0] out0,
  output logic [6:0] out1,
  output logic       isEnd,
  output logic       running
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t        state, state_n;
  logic [3:0]    c1, c0, c1_n, c0_n;
  logic [PW-1:0] presc, presc_n;
  logic          end_n;
  logic          tick;

  assign tick = (state == RUN) && (presc == LAST);

  always_comb begin
    state_n = state;
    c1_n    = c1;
    c0_n    = c0;
    presc_n = presc;
    end_n   = isEnd;
    if (load) begin
      c1_n    = (preset1 > 4'd9) ? 4'd9 : preset1;
      c0_n    = (preset0 > 4'd9) ? 4'd9 : preset0;
      state_n = IDLE;
      presc_n = '0;
      end_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          presc_n = '0;
          if (start && (c1 != 4'd0 || c0 != 4'd0))
            state_n = RUN;
        end
        RUN: begin
          if (pause) begin
            state_n = PAUSE;
          end else if (tick) begin
            presc_n = '0;
            if (c1 == 4'd0 && c0 == 4'd1) begin
              c0_n    = 4'd0;
              state_n = DONE;
              end_n   = 1'b1;
            end else if (c0 != 4'd0) begin
              c0_n = c0 - 4'd1;
            end else begin
              c0_n = 4'd9;
              c1_n = c1 - 4'd1;
            end
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        PAUSE: begin
          if (!pause)
            state_n = RUN;
        end
        DONE: begin
          presc_n = '0;
          end_n   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      c1      <= 4'd0;
      c0      <= 4'd0;
      presc   <= '0;
      isEnd   <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      c1      <= c1_n;
      c0      <= c0_n;
      presc   <= presc_n;
      isEnd   <= end_n;
      running <= (state_n == RUN);
    end
  end

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  assign out0 = seg(c0);
  assign out1 = seg(c1);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with CLK_DIV=4:
// vector table plus multi-cycle countdown/pause sequences.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] preset1 = 4'd0;
  logic [3:0] preset0 = 4'd0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [6:0] out0, out1;
  logic       isEnd, running;

  int tests = 0;
  int fails = 0;

  countdown_timer #(.CLK_DIV(4)) dut (
    .clk(clk),
    .reset(reset),
    .preset1(preset1),
    .preset0(preset0),
    .load(load),
    .start(start),
    .pause(pause),
    .out0(out0),
    .out1(out1),
    .isEnd(isEnd),
    .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic       st;
    logic       ps;
    logic [3:0] p1;
    logic [3:0] p0;
    logic [3:0] e1;
    logic [3:0] e0;
    logic       ee;
    logic       er;
  } vec_t;

  vec_t v[11];

  function automatic logic [6:0] segx(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (d < 4'd10) ? tbl[d] : 7'h7F;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] e1,
                         input logic [3:0] e0, input logic ee,
                         input logic er);
    chk({nm, ".out1"}, 32'(out1), 32'(segx(e1)));
    chk({nm, ".out0"}, 32'(out0), 32'(segx(e0)));
    chk({nm, ".isEnd"}, 32'(isEnd), 32'(ee));
    chk({nm, ".running"}, 32'(running), 32'(er));
  endtask

  task automatic do_load(input logic [3:0] a, input logic [3:0] b);
    preset1 = a;
    preset0 = b;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    //       rst ld st ps p1 p0 e1 e0 ee er
    v[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[2]  = '{1, 1, 0, 0, 2, 5, 2, 5, 0, 0};
    v[3]  = '{1, 0, 0, 0, 2, 5, 2, 5, 0, 0};
    v[4]  = '{1, 1, 0, 0, 12, 15, 9, 9, 0, 0};
    v[5]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    v[6]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    v[7]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    v[8]  = '{1, 1, 1, 0, 3, 7, 3, 7, 0, 0};
    v[9]  = '{1, 1, 1, 1, 3, 7, 3, 7, 0, 0};
    v[10] = '{0, 1, 0, 0, 4, 4, 0, 0, 0, 0};

    for (int i = 0; i < 11; i++) begin
      reset   = v[i].rst;
      load    = v[i].ld;
      start   = v[i].st;
      pause   = v[i].ps;
      preset1 = v[i].p1;
      preset0 = v[i].p0;
      step(1);
      chk_all($sformatf("vec%0d", i), v[i].e1, v[i].e0,
              v[i].ee, v[i].er);
    end
    reset = 1'b1;
    load = 1'b0;
    start = 1'b0;
    pause = 1'b0;

    // countdown 10 -> 00 with borrow, then DONE holds
    do_load(4'd1, 4'd0);
    start = 1'b1;
    step(1);
    chk_all("borrow.run", 1, 0, 0, 1);
    start = 1'b0;
    step(3);
    chk_all("borrow.pre", 1, 0, 0, 1);
    step(1);
    chk_all("borrow.09", 0, 9, 0, 1);
    step(32);
    chk_all("borrow.01", 0, 1, 0, 1);
    step(4);
    chk_all("borrow.done", 0, 0, 1, 0);
    start = 1'b1;
    pause = 1'b1;
    step(20);
    chk_all("done.hold", 0, 0, 1, 0);
    start = 1'b0;
    pause = 1'b0;
    reset = 1'b0;
    step(1);
    chk_all("done.reset", 0, 0, 0, 0);
    reset = 1'b1;

    // pause at prescaler 2, then pause coinciding with tick
    do_load(4'd0, 4'd3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    pause = 1'b1;
    step(1);
    chk_all("pause.enter", 0, 3, 0, 0);
    step(9);
    chk_all("pause.hold", 0, 3, 0, 0);
    pause = 1'b0;
    step(1);
    chk_all("pause.resume", 0, 3, 0, 1);
    step(1);
    chk_all("pause.p3", 0, 3, 0, 1);
    step(1);
    chk_all("pause.dec", 0, 2, 0, 1);
    step(3);
    chk_all("tick.pre", 0, 2, 0, 1);
    pause = 1'b1;
    step(1);
    chk_all("tick.paused", 0, 2, 0, 0);
    pause = 1'b0;
    step(1);
    chk_all("tick.resume", 0, 2, 0, 1);
    step(1);
    chk_all("tick.dec", 0, 1, 0, 1);

    // load during RUN at 57, then reset during RUN at 42
    do_load(4'd5, 4'd9);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(8);
    chk_all("run.57", 5, 7, 0, 1);
    step(1);
    do_load(4'd4, 4'd2);
    chk_all("reload.42", 4, 2, 0, 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    chk_all("reload.p3", 4, 2, 0, 1);
    step(1);
    chk_all("reload.41", 4, 1, 0, 1);
    do_load(4'd4, 4'd2);
    start = 1'b1;
    step(2);
    start = 1'b0;
    chk_all("run.42", 4, 2, 0, 1);
    reset = 1'b0;
    step(1);
    chk_all("run.reset", 0, 0, 0, 0);
    reset = 1'b1;
    step(1);
    chk_all("post.reset", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
